// File: rtl/axi4_pkg.sv
// Shared AXI4 constants, helper function and DMA FSM state encoding.
package axi4_pkg;

  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam int unsigned PAGE_BYTES = 4096;

  // Ceiling log2 usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_DONE
  } dma_state_e;

endpackage

// File: rtl/axi4_burst_calc.sv
// Burst sizing: beats limited by remaining length, MAX_BURST and the 4 KB page end.
module axi4_burst_calc
  import axi4_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MAX_BURST  = 256,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic [11:0]          page_off,
  input  logic [LEN_WIDTH-1:0] remaining,
  output logic [8:0]           beats,
  output logic [7:0]           ax_len
);

  localparam int unsigned SIZE   = clog2(DATA_WIDTH / 8);
  localparam int unsigned CALC_W = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  logic [CALC_W-1:0] page_beats;
  logic [CALC_W-1:0] cand;

  always_comb begin
    page_beats = CALC_W'((13'(PAGE_BYTES) - {1'b0, page_off}) >> SIZE);
    cand       = CALC_W'(remaining);
    if (page_beats < cand) cand = page_beats;
    if (CALC_W'(MAX_BURST) < cand) cand = CALC_W'(MAX_BURST);
    beats  = 9'(cand);
    ax_len = 8'(cand - CALC_W'(1));
  end

endmodule

// File: rtl/axi4_burst_dma.sv
// AXI4 burst master: splits one read/write command into page-safe INCR bursts
// and streams local data through valid/ready ports.
module axi4_burst_dma
  import axi4_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 256,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [ID_WIDTH-1:0]   awid_m_inf,
  output logic [ADDR_WIDTH-1:0] awaddr_m_inf,
  output logic [7:0]            awlen_m_inf,
  output logic [2:0]            awsize_m_inf,
  output logic [1:0]            awburst_m_inf,
  output logic                  awvalid_m_inf,
  input  logic                  awready_m_inf,
  output logic [DATA_WIDTH-1:0] wdata_m_inf,
  output logic                  wlast_m_inf,
  output logic                  wvalid_m_inf,
  input  logic                  wready_m_inf,
  input  logic [ID_WIDTH-1:0]   bid_m_inf,
  input  logic [1:0]            bresp_m_inf,
  input  logic                  bvalid_m_inf,
  output logic                  bready_m_inf,
  output logic [ID_WIDTH-1:0]   arid_m_inf,
  output logic [ADDR_WIDTH-1:0] araddr_m_inf,
  output logic [7:0]            arlen_m_inf,
  output logic [2:0]            arsize_m_inf,
  output logic [1:0]            arburst_m_inf,
  output logic                  arvalid_m_inf,
  input  logic                  arready_m_inf,
  input  logic [ID_WIDTH-1:0]   rid_m_inf,
  input  logic [DATA_WIDTH-1:0] rdata_m_inf,
  input  logic [1:0]            rresp_m_inf,
  input  logic                  rlast_m_inf,
  input  logic                  rvalid_m_inf,
  output logic                  rready_m_inf
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned SIZE  = clog2(BYTES);
  localparam int unsigned BW    = 9;

  dma_state_e            state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [LEN_WIDTH-1:0]  rem_q, rem_nxt;
  logic [BW-1:0]         beats_q, beat_cnt, calc_beats;
  logic [7:0]            len_q, calc_len;
  logic                  write_q, write_nxt;
  logic                  accept, addr_hs, r_hs, w_hs, b_hs;
  logic                  last_beat, final_burst, in_rd, in_wr;
  logic                  r_bad, b_bad;

  axi4_burst_calc #(
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_BURST (MAX_BURST),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_calc (
    .page_off (addr_nxt[11:0]),
    .remaining(rem_nxt),
    .beats    (calc_beats),
    .ax_len   (calc_len)
  );

  // Handshake and burst-position decode.
  always_comb begin
    accept      = cmd_valid & cmd_ready;
    in_rd       = (state == S_DATA) & ~write_q;
    in_wr       = (state == S_DATA) & write_q;
    addr_hs     = write_q ? (awvalid_m_inf & awready_m_inf) : (arvalid_m_inf & arready_m_inf);
    r_hs        = in_rd & rvalid_m_inf & rd_ready;
    w_hs        = in_wr & wr_valid & wready_m_inf;
    b_hs        = bvalid_m_inf & bready_m_inf;
    last_beat   = (beat_cnt == beats_q - BW'(1));
    final_burst = (rem_q == LEN_WIDTH'(beats_q));
    r_bad       = (rresp_m_inf != RESP_OKAY) | (rid_m_inf != ID_WIDTH'(AXI_ID)) |
                  (rlast_m_inf != last_beat);
    b_bad       = (bresp_m_inf != RESP_OKAY) | (bid_m_inf != ID_WIDTH'(AXI_ID));
  end

  // Next state plus the address/length that the next burst starts from.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q + (ADDR_WIDTH'(beats_q) << SIZE);
    rem_nxt   = rem_q - LEN_WIDTH'(beats_q);
    write_nxt = write_q;
    case (state)
      S_IDLE: if (accept) begin
        addr_nxt  = cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
        rem_nxt   = cmd_len;
        write_nxt = cmd_write;
        state_nxt = (cmd_len == '0) ? S_DONE : S_ADDR;
      end
      S_ADDR: if (addr_hs) state_nxt = S_DATA;
      S_DATA: if ((r_hs | w_hs) & last_beat)
        state_nxt = write_q ? S_RESP : (final_burst ? S_DONE : S_ADDR);
      S_RESP: if (b_hs) state_nxt = final_burst ? S_DONE : S_ADDR;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      rem_q         <= '0;
      beats_q       <= '0;
      len_q         <= '0;
      beat_cnt      <= '0;
      write_q       <= 1'b0;
      arvalid_m_inf <= 1'b0;
      awvalid_m_inf <= 1'b0;
      bready_m_inf  <= 1'b0;
      cmd_ready     <= 1'b1;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state   <= state_nxt;
      write_q <= write_nxt;
      // Burst parameters are captured once and held until the address handshake.
      if ((state_nxt == S_ADDR) && (state != S_ADDR)) begin
        addr_q  <= addr_nxt;
        rem_q   <= rem_nxt;
        beats_q <= calc_beats;
        len_q   <= calc_len;
      end
      if ((state == S_ADDR) && addr_hs) beat_cnt <= '0;
      else if (r_hs | w_hs)              beat_cnt <= beat_cnt + BW'(1);
      arvalid_m_inf <= (state_nxt == S_ADDR) & ~write_nxt;
      awvalid_m_inf <= (state_nxt == S_ADDR) & write_nxt;
      bready_m_inf  <= (state_nxt == S_RESP);
      cmd_ready     <= (state_nxt == S_IDLE);
      done          <= (state_nxt == S_DONE);
      if (accept)              err <= 1'b0;
      else if (r_hs & r_bad)   err <= 1'b1;
      else if (b_hs & b_bad)   err <= 1'b1;
    end
  end

  assign arid_m_inf    = ID_WIDTH'(AXI_ID);
  assign araddr_m_inf  = addr_q;
  assign arlen_m_inf   = len_q;
  assign arsize_m_inf  = 3'(SIZE);
  assign arburst_m_inf = BURST_INCR;
  assign awid_m_inf    = ID_WIDTH'(AXI_ID);
  assign awaddr_m_inf  = addr_q;
  assign awlen_m_inf   = len_q;
  assign awsize_m_inf  = 3'(SIZE);
  assign awburst_m_inf = BURST_INCR;

  // Stream pass-through, gated by the active data phase.
  assign rready_m_inf = in_rd & rd_ready;
  assign rd_valid     = in_rd & rvalid_m_inf;
  assign rd_data      = rdata_m_inf;
  assign rd_last      = rd_valid & rlast_m_inf & final_burst;
  assign wvalid_m_inf = in_wr & wr_valid;
  assign wr_ready     = in_wr & wready_m_inf;
  assign wdata_m_inf  = wr_data;
  assign wlast_m_inf  = in_wr & last_beat;

endmodule

// File: tb/tb_axi4_burst_dma.sv
// Directed bench for axi4_burst_dma with a reactive AXI slave and local stream model.
module tb_axi4_burst_dma;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
  } ax_t;

  logic clk = 1'b0;
  logic rst_n;
  logic cmd_valid, cmd_ready, cmd_write, done, err;
  logic [AW-1:0] cmd_addr;
  logic [15:0]   cmd_len;
  logic [DW-1:0] rd_data, wr_data, wdata, rdata;
  logic rd_valid, rd_last, rd_ready, wr_valid, wr_ready;
  logic [3:0] awid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi4_burst_dma #(
    .ID_WIDTH(4), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .MAX_BURST(256), .LEN_WIDTH(16), .AXI_ID(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .done(done), .err(err),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .awid_m_inf(awid), .awaddr_m_inf(awaddr), .awlen_m_inf(awlen), .awsize_m_inf(awsize),
    .awburst_m_inf(awburst), .awvalid_m_inf(awvalid), .awready_m_inf(awready),
    .wdata_m_inf(wdata), .wlast_m_inf(wlast), .wvalid_m_inf(wvalid), .wready_m_inf(wready),
    .bid_m_inf(bid), .bresp_m_inf(bresp), .bvalid_m_inf(bvalid), .bready_m_inf(bready),
    .arid_m_inf(arid), .araddr_m_inf(araddr), .arlen_m_inf(arlen), .arsize_m_inf(arsize),
    .arburst_m_inf(arburst), .arvalid_m_inf(arvalid), .arready_m_inf(arready),
    .rid_m_inf(rid), .rdata_m_inf(rdata), .rresp_m_inf(rresp), .rlast_m_inf(rlast),
    .rvalid_m_inf(rvalid), .rready_m_inf(rready)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave / stream model state
  ax_t ar_log[$];
  ax_t aw_log[$];
  int  rq[$];
  int  r_beat, r_seq, rd_got_cnt, rd_last_cnt, rd_last_idx, rd_order_err;
  int  ar_wait, ar_wait_max, ar_delay, ar_unstable;
  logic [31:0] ar_first_addr;
  logic [7:0]  ar_first_len;
  int  w_cnt, w_data_err, b_pend, b_cnt, b_idx, done_cnt;
  logic [15:0] wlast_mask;
  logic [1:0]  bresp_plan [4];
  logic        rd_toggle;

  task automatic clear_logs();
    ar_log.delete(); aw_log.delete();
    r_seq = 0; rd_got_cnt = 0; rd_last_cnt = 0; rd_last_idx = -1; rd_order_err = 0;
    ar_wait_max = 0; ar_unstable = 0;
    w_cnt = 0; w_data_err = 0; wlast_mask = '0; b_cnt = 0; b_idx = 0; done_cnt = 0;
  endtask

  function automatic ax_t ar_at(input int i);
    ax_t d;
    d = '1;
    if (i < ar_log.size()) d = ar_log[i];
    return d;
  endfunction

  function automatic ax_t aw_at(input int i);
    ax_t d;
    d = '1;
    if (i < aw_log.size()) d = aw_log[i];
    return d;
  endfunction

  // Drive slave/stream inputs on the falling edge, then sample handshakes that the next rising edge takes.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rq.delete(); r_beat = 0; b_pend = 0; ar_wait = 0;
        arready = 0; awready = 0; rvalid = 0; rlast = 0; bvalid = 0; rd_ready = 1; wr_valid = 0;
        wready = 0; rdata = '0; wr_data = '0; rresp = 0; rid = 0; bresp = 0; bid = 0;
      end else begin
        arready = arvalid && (ar_wait >= ar_delay);
        awready = awvalid;
        rvalid  = (rq.size() > 0);
        rlast   = (rq.size() > 0) && (r_beat == rq[0] - 1);
        rdata   = {96'h0, 32'hD000_0000 + 32'(r_seq)};
        rresp   = 2'b00;
        rid     = 4'd0;
        rd_ready = rd_toggle ? ~rd_ready : 1'b1;
        wready   = 1'b1;
        wr_valid = 1'b1;
        wr_data  = {96'h0, 32'hC000_0000 + 32'(w_cnt)};
        bvalid   = (b_pend > 0);
        bresp    = bresp_plan[b_idx[1:0]];
        bid      = 4'd0;
        #1;
        if (arvalid) begin
          if (ar_wait == 0) begin
            ar_first_addr = araddr; ar_first_len = arlen;
          end else if (araddr != ar_first_addr || arlen != ar_first_len) ar_unstable++;
          if (arready) begin
            ar_log.push_back('{araddr, arlen, arsize, arburst, arid});
            rq.push_back(int'(arlen) + 1);
            if (ar_wait > ar_wait_max) ar_wait_max = ar_wait;
            ar_wait = 0;
          end else ar_wait++;
        end
        if (rvalid && rready) begin
          r_seq++; r_beat++;
          if (r_beat == rq[0]) begin void'(rq.pop_front()); r_beat = 0; end
        end
        if (rd_valid && rd_ready) begin
          if (rd_data[31:0] != 32'hD000_0000 + 32'(rd_got_cnt)) rd_order_err++;
          if (rd_last) begin rd_last_cnt++; rd_last_idx = rd_got_cnt; end
          rd_got_cnt++;
        end
        if (awvalid && awready) aw_log.push_back('{awaddr, awlen, awsize, awburst, awid});
        if (wvalid && wready) begin
          if (wdata[31:0] != 32'hC000_0000 + 32'(w_cnt)) w_data_err++;
          if (wlast) begin
            if (w_cnt < 16) wlast_mask[w_cnt[3:0]] = 1'b1;
            b_pend++;
          end
          w_cnt++;
        end
        if (bvalid && bready) begin b_pend--; b_cnt++; b_idx++; end
        if (done) done_cnt++;
      end
    end
  end

  task automatic run_cmd(input string tag, input logic wr, input logic [31:0] a,
                         input logic [15:0] n, input int budget);
    int t;
    @(negedge clk);
    clear_logs();
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = n;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    @(negedge clk);
    #2;
    chk({tag, "_done_width"}, 64'(done_cnt), 64'd1);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    rd_ready = 1; wr_valid = 0; wr_data = '0;
    arready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    rvalid = 0; rlast = 0; rresp = 0; rid = 0; rdata = '0;
    ar_delay = 0; rd_toggle = 0;
    for (int i = 0; i < 4; i++) bresp_plan[i] = 2'b00;
    clear_logs();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", 64'({arvalid, awvalid, wvalid, bready, rready, done, err, rd_valid, wr_ready, cmd_ready}),
        64'b00_0000_0001);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single short read burst
    run_cmd("t1", 1'b0, 32'h0001_0000, 16'd4, 200);
    chk("t1_ar_count", 64'(ar_log.size()), 64'd1);
    chk("t1_ar0", 64'(ar_at(0)), 64'({32'h0001_0000, 8'd3, 3'd4, 2'b01, 4'd0}));
    chk("t1_rd_beats", 64'(rd_got_cnt), 64'd4);
    chk("t1_rd_last", 64'({rd_last_cnt[7:0], rd_last_idx[7:0]}), 64'h0103);
    chk("t1_rd_order", 64'(rd_order_err), 64'd0);
    chk("t1_err", 64'(err), 64'd0);

    // 2: read split at MAX_BURST / page boundary
    run_cmd("t2", 1'b0, 32'h0001_0000, 16'd300, 2000);
    chk("t2_ar_count", 64'(ar_log.size()), 64'd2);
    chk("t2_ar0", 64'({ar_at(0).addr, ar_at(0).len}), 64'({32'h0001_0000, 8'd255}));
    chk("t2_ar1", 64'({ar_at(1).addr, ar_at(1).len}), 64'({32'h0001_1000, 8'd43}));
    chk("t2_rd_beats", 64'(rd_got_cnt), 64'd300);
    chk("t2_rd_last", 64'(rd_last_cnt), 64'd1);
    chk("t2_rd_last_idx", 64'(rd_last_idx), 64'd299);
    chk("t2_rd_order", 64'(rd_order_err), 64'd0);

    // 3: write crossing a 4 KB page
    run_cmd("t3", 1'b1, 32'h0001_0FC0, 16'd8, 400);
    chk("t3_aw_count", 64'(aw_log.size()), 64'd2);
    chk("t3_aw0", 64'(aw_at(0)), 64'({32'h0001_0FC0, 8'd3, 3'd4, 2'b01, 4'd0}));
    chk("t3_aw1", 64'({aw_at(1).addr, aw_at(1).len}), 64'({32'h0001_1000, 8'd3}));
    chk("t3_w_beats", 64'(w_cnt), 64'd8);
    chk("t3_wlast_mask", 64'(wlast_mask), 64'h0088);
    chk("t3_b_count", 64'(b_cnt), 64'd2);
    chk("t3_wdata", 64'(w_data_err), 64'd0);
    chk("t3_no_ar", 64'(ar_log.size()), 64'd0);
    chk("t3_err", 64'(err), 64'd0);

    // 4: delayed arready and throttled consumer
    ar_delay = 5; rd_toggle = 1'b1;
    run_cmd("t4", 1'b0, 32'h0003_0000, 16'd16, 400);
    ar_delay = 0; rd_toggle = 1'b0;
    chk("t4_ar0", 64'({ar_at(0).addr, ar_at(0).len}), 64'({32'h0003_0000, 8'd15}));
    chk("t4_ar_wait", 64'(ar_wait_max), 64'd5);
    chk("t4_ar_stable", 64'(ar_unstable), 64'd0);
    chk("t4_rd_beats", 64'(rd_got_cnt), 64'd16);
    chk("t4_rd_order", 64'(rd_order_err), 64'd0);
    chk("t4_rd_last_idx", 64'(rd_last_idx), 64'd15);

    // 5: SLVERR on first write response, then a zero-length command clears err
    bresp_plan[0] = 2'b10;
    run_cmd("t5", 1'b1, 32'h0002_0FE0, 16'd6, 400);
    bresp_plan[0] = 2'b00;
    chk("t5_aw0", 64'({aw_at(0).addr, aw_at(0).len}), 64'({32'h0002_0FE0, 8'd1}));
    chk("t5_aw1", 64'({aw_at(1).addr, aw_at(1).len}), 64'({32'h0002_1000, 8'd3}));
    chk("t5_wlast_mask", 64'(wlast_mask), 64'h0022);
    chk("t5_b_count", 64'(b_cnt), 64'd2);
    chk("t5_err_set", 64'(err), 64'd1);
    run_cmd("t5b", 1'b0, 32'h0000_0000, 16'd0, 20);
    chk("t5_err_cleared", 64'(err), 64'd0);

    // 6: reset in the middle of a write, then a zero-length command
    @(negedge clk);
    clear_logs();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0004_0000; cmd_len = 16'd8;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (w_cnt < 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("t6_w_started", 64'(w_cnt >= 2), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outs", 64'({arvalid, awvalid, wvalid, bready, rready, done, rd_valid, wr_ready, cmd_ready}),
        64'b0_0000_0001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0005_0000; cmd_len = 16'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t6_done_pulse", 64'({done, cmd_ready}), 64'b10);
    @(negedge clk);
    chk("t6_done_end", 64'({done, cmd_ready}), 64'b01);
    repeat (3) @(negedge clk);
    #2;
    chk("t6_no_axi", 64'(ar_log.size() + aw_log.size() + w_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
